tile_loop_scheduler: RTL and testbench

//   Sequences a 3-level tiled loop nest (tile0 innermost .. tile2 outermost) for the CNN accelerator.
//   For each tile it runs load -> compute -> store, one phase at a time, via start/done handshakes.
//   It drives the tile indices consumed by the address generators and nested tile counters.

---
 rtl/tile_loop_scheduler.sv | 111 +++++++++++
 tb/tb_tile_loop_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tile_loop_scheduler.sv
// rtl/tile_loop_scheduler.sv - 3-level tiled loop nest sequencer (load -> compute -> store per tile)
module tile_loop_scheduler #(
   parameter int CW     = 16,
   parameter int N0_MAX = 4,
   parameter int N1_MAX = 2,
   parameter int N2_MAX = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          load_start,
   input  logic          load_done,
   output logic          comp_start,
   input  logic          comp_done,
   output logic          store_start,
   input  logic          store_done,
   output logic [CW-1:0] tile0,
   output logic [CW-1:0] tile1,
   output logic [CW-1:0] tile2,
   output logic          last_tile,
   output logic          busy,
   output logic          done
);

   localparam logic [CW-1:0] T0_LAST = CW'(N0_MAX - 1);
   localparam logic [CW-1:0] T1_LAST = CW'(N1_MAX - 1);
   localparam logic [CW-1:0] T2_LAST = CW'(N2_MAX - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, WAIT_LOAD, COMP, WAIT_COMP, STORE, WAIT_STORE, FINISH
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] tile0_nxt, tile1_nxt, tile2_nxt;
   logic          wrap0, wrap1, wrap2;

   assign wrap0     = (tile0 == T0_LAST);
   assign wrap1     = (tile1 == T1_LAST);
   assign wrap2     = (tile2 == T2_LAST);
   assign last_tile = wrap0 && wrap1 && wrap2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         tile0 <= '0;
         tile1 <= '0;
         tile2 <= '0;
      end else begin
         state <= state_nxt;
         tile0 <= tile0_nxt;
         tile1 <= tile1_nxt;
         tile2 <= tile2_nxt;
      end
   end

   // Indices only move on the IDLE->LOAD edge (clear) and the WAIT_STORE->LOAD edge (advance),
   // so they stay stable for the whole load/compute/store of one tile.
   always_comb begin
      state_nxt = state;
      tile0_nxt = tile0;
      tile1_nxt = tile1;
      tile2_nxt = tile2;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
               tile0_nxt = '0;
               tile1_nxt = '0;
               tile2_nxt = '0;
            end
         end
         LOAD:      state_nxt = WAIT_LOAD;
         WAIT_LOAD: if (load_done) state_nxt = COMP;
         COMP:      state_nxt = WAIT_COMP;
         WAIT_COMP: if (comp_done) state_nxt = STORE;
         STORE:     state_nxt = WAIT_STORE;
         WAIT_STORE: begin
            if (store_done) begin
               if (last_tile) begin
                  state_nxt = FINISH;
               end else begin
                  state_nxt = LOAD;
                  tile0_nxt = wrap0 ? '0 : tile0 + 1'b1;
                  if (wrap0) begin
                     tile1_nxt = wrap1 ? '0 : tile1 + 1'b1;
                     if (wrap1) tile2_nxt = wrap2 ? '0 : tile2 + 1'b1;
                  end
               end
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load_start  = 1'b0;
      comp_start  = 1'b0;
      store_start = 1'b0;
      done        = 1'b0;
      busy        = (state != IDLE);
      case (state)
         LOAD:    load_start  = 1'b1;
         COMP:    comp_start  = 1'b1;
         STORE:   store_start = 1'b1;
         FINISH:  done        = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tile_loop_scheduler.sv
// tb/tb_tile_loop_scheduler.sv - directed bench for tile_loop_scheduler (default and all-ones nests)
module tb_tile_loop_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_start, b_start;
   logic        a_load_start, a_comp_start, a_store_start, a_done, a_busy, a_last_tile;
   logic        b_load_start, b_comp_start, b_store_start, b_done, b_busy, b_last_tile;
   logic [15:0] a_tile0, a_tile1, a_tile2, b_tile0, b_tile1, b_tile2;
   logic        r_load_done = 1'b0, r_comp_done = 1'b0, r_store_done = 1'b0;
   logic        m_load_done = 1'b0, m_comp_done = 1'b0, m_store_done = 1'b0;
   logic        b_load_done = 1'b0, b_comp_done = 1'b0, b_store_done = 1'b0;
   logic        b_prev_ld = 1'b0, b_prev_cp = 1'b0, b_prev_st = 1'b0;
   wire         a_load_done  = r_load_done  | m_load_done;
   wire         a_comp_done  = r_comp_done  | m_comp_done;
   wire         a_store_done = r_store_done | m_store_done;

   int n_checks = 0, n_pass = 0;
   int cyc = 0, base = 0;
   bit auto_en = 1'b1, rand_mode = 1'b0;

   // monitor state (written only by the monitor process)
   int a_done_cnt = 0, a_done_cyc = -1, b_done_cnt = 0, b_done_cyc = -1;
   int n_ld = 0, n_cp = 0, n_st = 0, b_ld = 0, b_lt_bad = 0;
   int ovl_err = 0, stab_err = 0, cur = 0;
   bit outst = 1'b0;
   int tq[$];
   bit lq[$];

   tile_loop_scheduler #(.CW(16), .N0_MAX(4), .N1_MAX(2), .N2_MAX(3)) dut_a (
      .clk(clk), .rst(rst), .start(a_start),
      .load_start(a_load_start), .load_done(a_load_done),
      .comp_start(a_comp_start), .comp_done(a_comp_done),
      .store_start(a_store_start), .store_done(a_store_done),
      .tile0(a_tile0), .tile1(a_tile1), .tile2(a_tile2),
      .last_tile(a_last_tile), .busy(a_busy), .done(a_done)
   );

   tile_loop_scheduler #(.CW(16), .N0_MAX(1), .N1_MAX(1), .N2_MAX(1)) dut_b (
      .clk(clk), .rst(rst), .start(b_start),
      .load_start(b_load_start), .load_done(b_load_done),
      .comp_start(b_comp_start), .comp_done(b_comp_done),
      .store_start(b_store_start), .store_done(b_store_done),
      .tile0(b_tile0), .tile1(b_tile1), .tile2(b_tile2),
      .last_tile(b_last_tile), .busy(b_busy), .done(b_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int pick_delay();
      return rand_mode ? 1 + int'($urandom_range(0, 20)) : 1;
   endfunction

   function automatic int a_tuple();
      return int'(a_tile2) * 100 + int'(a_tile1) * 10 + int'(a_tile0);
   endfunction

   // engine responders for dut_a: done comes pick_delay() cycles after the start pulse
   always begin
      @(negedge clk);
      if (auto_en && a_load_start) begin
         repeat (pick_delay()) @(negedge clk);
         r_load_done = 1'b1;
         @(negedge clk);
         r_load_done = 1'b0;
      end
   end
   always begin
      @(negedge clk);
      if (auto_en && a_comp_start) begin
         repeat (pick_delay()) @(negedge clk);
         r_comp_done = 1'b1;
         @(negedge clk);
         r_comp_done = 1'b0;
      end
   end
   always begin
      @(negedge clk);
      if (auto_en && a_store_start) begin
         repeat (pick_delay()) @(negedge clk);
         r_store_done = 1'b1;
         @(negedge clk);
         r_store_done = 1'b0;
      end
   end

   // dut_b responder: every done exactly one cycle after its start
   always begin
      @(negedge clk);
      b_load_done  = b_prev_ld;  b_prev_ld = b_load_start;
      b_comp_done  = b_prev_cp;  b_prev_cp = b_comp_start;
      b_store_done = b_prev_st;  b_prev_st = b_store_start;
   end

   always begin
      @(negedge clk);
      #1;
      if (a_done) begin a_done_cnt++; a_done_cyc = cyc - base; end
      if (a_load_done || a_comp_done || a_store_done) outst = 1'b0;
      if (a_load_start || a_comp_start || a_store_start) begin
         if (outst) ovl_err++;
         outst = 1'b1;
      end
      if (a_load_start) begin
         n_ld++;
         cur = a_tuple();
         tq.push_back(cur);
         lq.push_back(a_last_tile);
      end
      if (a_comp_start) begin n_cp++; if (a_tuple() != cur) stab_err++; end
      if (a_store_start) begin n_st++; if (a_tuple() != cur) stab_err++; end
      if (b_done) begin b_done_cnt++; b_done_cyc = cyc - base; end
      if (b_load_start) b_ld++;
      if (!b_last_tile || b_tile0 != 0 || b_tile1 != 0 || b_tile2 != 0) b_lt_bad++;
   end

   initial begin
      int q0, d0, ld0, cp0, st0, ov0, sb0, bd0, bl0, exp_t;
      bit found;
      rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
      tick(); tick();
      check("rst_load_start", a_load_start, 0);
      check("rst_comp_start", a_comp_start, 0);
      check("rst_store_start", a_store_start, 0);
      check("rst_done", a_done, 0);
      check("rst_busy", a_busy, 0);
      check("rst_tiles", {a_tile2, a_tile1, a_tile0}, 0);
      check("rst_last_tile", a_last_tile, 0);
      check("rst_b_last_tile", b_last_tile, 1);
      rst = 1'b0;
      tick();

      // fixed 1-cycle responders on both instances
      q0 = tq.size(); d0 = a_done_cnt; ld0 = n_ld; bd0 = b_done_cnt; bl0 = b_ld;
      a_start = 1'b1; b_start = 1'b1; base = cyc;
      tick();
      a_start = 1'b0; b_start = 1'b0;
      check("first_load_cycle1", a_load_start, 1);
      while (cyc - base < 146) tick();
      check("busy_low_146", a_busy, 0);
      check("done_count", a_done_cnt - d0, 1);
      check("done_cycle", a_done_cyc, 145);
      check("load_count", n_ld - ld0, 24);
      for (int i = 0; i < 24; i++) begin
         exp_t = (i / 8) * 100 + ((i / 4) % 2) * 10 + (i % 4);
         check($sformatf("tuple_%0d", i), (q0 + i < tq.size()) ? tq[q0 + i] : -1, exp_t);
         check($sformatf("last_%0d", i), (q0 + i < lq.size()) ? lq[q0 + i] : 2, (i == 23));
      end
      check("b_done_count", b_done_cnt - bd0, 1);
      check("b_done_cycle", b_done_cyc, 7);
      check("b_load_count", b_ld - bl0, 1);
      check("b_last_tile_bad", b_lt_bad, 0);

      // random done delays
      rand_mode = 1'b1;
      d0 = a_done_cnt; ld0 = n_ld; cp0 = n_cp; st0 = n_st; ov0 = ovl_err; sb0 = stab_err;
      a_start = 1'b1; base = cyc;
      tick();
      a_start = 1'b0;
      for (int k = 0; k < 5000 && a_done_cnt == d0; k++) tick();
      check("rand_done", a_done_cnt - d0, 1);
      check("rand_loads", n_ld - ld0, 24);
      check("rand_comps", n_cp - cp0, 24);
      check("rand_stores", n_st - st0, 24);
      check("rand_overlap", ovl_err - ov0, 0);
      check("rand_stable", stab_err - sb0, 0);
      rand_mode = 1'b0;
      tick(); tick();

      // spurious done pulses and start while busy, driven by hand
      auto_en = 1'b0;
      m_store_done = 1'b1; tick(); m_store_done = 1'b0; tick();
      check("idle_spur_busy", a_busy, 0);
      check("idle_spur_tiles", a_tuple(), 213);
      a_start = 1'b1; tick(); a_start = 1'b0;
      check("man_load_start", a_load_start, 1);
      check("man_tiles_cleared", a_tuple(), 0);
      tick();
      m_load_done = 1'b1; tick(); m_load_done = 1'b0;
      check("man_comp_start", a_comp_start, 1);
      tick();
      m_load_done = 1'b1; a_start = 1'b1; tick(); m_load_done = 1'b0; a_start = 1'b0;
      check("spur_pulses", {a_load_start, a_comp_start, a_store_start}, 0);
      check("spur_busy", a_busy, 1);
      check("spur_tiles", a_tuple(), 0);
      m_comp_done = 1'b1; tick(); m_comp_done = 1'b0;
      check("man_store_start", a_store_start, 1);
      tick();
      m_store_done = 1'b1; tick(); m_store_done = 1'b0;
      check("man_next_load", a_load_start, 1);
      check("man_next_tiles", a_tuple(), 1);

      // asynchronous reset in WAIT_COMP of tile 5
      rst = 1'b1; tick(); rst = 1'b0; tick();
      auto_en = 1'b1;
      a_start = 1'b1; base = cyc; tick(); a_start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         if (a_comp_start && a_tuple() == 11) found = 1'b1;
         else tick();
      end
      check("reach_tile5", found, 1);
      tick();
      rst = 1'b1;
      #1;
      check("arst_pulses", {a_load_start, a_comp_start, a_store_start, a_done}, 0);
      check("arst_busy", a_busy, 0);
      check("arst_tiles", {a_tile2, a_tile1, a_tile0}, 0);
      tick(); tick();
      rst = 1'b0;
      tick(); tick();
      a_start = 1'b1; tick(); a_start = 1'b0;
      check("rerun_load", a_load_start, 1);
      check("rerun_tiles", a_tuple(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
